// File: rtl/pc_stack_unit_if.sv
// Control/status bundle between the decode unit and the PC/return-stack block.
// The decode side drives the strobes and targets; the PC unit returns PC and stack status.
interface pc_stack_unit_if #(
    parameter int ADDR_W      = 11,
    parameter int STACK_DEPTH = 4
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    logic              stall;
    logic              inc;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_addr;
    logic              call_en;
    logic [ADDR_W-1:0] call_addr;
    logic              ret_en;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ret_top;
    logic [CNT_W-1:0]  stack_count;
    logic              stack_full;
    logic              stack_empty;
    logic              ovf_err;
    logic              unf_err;

    modport master (
        output stall, inc, branch_en, branch_addr, call_en, call_addr, ret_en,
        input  pc, ret_top, stack_count, stack_full, stack_empty, ovf_err, unf_err
    );

    modport slave (
        input  stall, inc, branch_en, branch_addr, call_en, call_addr, ret_en,
        output pc, ret_top, stack_count, stack_full, stack_empty, ovf_err, unf_err
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with next-PC selection (ret > call > branch > inc) and an internal
// return-address stack with sticky overflow/underflow flags.
module pc_stack_unit #(
    parameter int                  ADDR_W      = 11,
    parameter int                  STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]   RESET_VEC   = {ADDR_W{1'b0}},
    localparam int                 CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    pc_stack_unit_if.slave    bus
);
    // Storage is sized to a power of two so stack indices never need a wider select.
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int ENTRIES = 1 << IDX_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ret_top_q, ret_top_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] mem_q [ENTRIES];
    logic [ADDR_W-1:0] mem_d [ENTRIES];

    logic [CNT_W-1:0]  cnt_m1_s, cnt_m2_s;
    logic [IDX_W-1:0]  top_idx_s, below_idx_s, wr_idx_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic              full_s, empty_s;

    assign full_s      = (count_q == CNT_W'(STACK_DEPTH));
    assign empty_s     = (count_q == CNT_W'(0));
    assign cnt_m1_s    = count_q - CNT_W'(1);
    assign cnt_m2_s    = count_q - CNT_W'(2);
    assign top_idx_s   = cnt_m1_s[IDX_W-1:0];
    assign below_idx_s = cnt_m2_s[IDX_W-1:0];
    assign wr_idx_s    = count_q[IDX_W-1:0];
    assign pc_inc_s    = pc_q + ADDR_W'(1);

    // Next-state selection; ret_top is tracked alongside the stack so it is a plain flop.
    always_comb begin
        pc_d      = pc_q;
        ret_top_d = ret_top_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        mem_d     = mem_q;
        if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.ret_en) begin
            if (empty_s) begin
                unf_d = 1'b1;
            end else begin
                pc_d    = mem_q[top_idx_s];
                count_d = cnt_m1_s;
                if (count_q == CNT_W'(1)) begin
                    ret_top_d = {ADDR_W{1'b0}};
                end else begin
                    ret_top_d = mem_q[below_idx_s];
                end
            end
        end else if (bus.call_en) begin
            if (full_s) begin
                ovf_d = 1'b1;
            end else begin
                mem_d[wr_idx_s] = pc_inc_s;
                ret_top_d       = pc_inc_s;
                pc_d            = bus.call_addr;
                count_d         = count_q + CNT_W'(1);
            end
        end else if (bus.branch_en) begin
            pc_d = bus.branch_addr;
        end else if (bus.inc) begin
            pc_d = pc_inc_s;
        end else begin
            pc_d = pc_q;
        end
    end

    // State registers; reset overrides stall and any in-flight call/return.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_VEC;
            ret_top_q <= {ADDR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ret_top_q <= ret_top_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            mem_q     <= mem_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.ret_top     = ret_top_q;
    assign bus.stack_count = count_q;
    assign bus.stack_full  = full_s;
    assign bus.stack_empty = empty_s;
    assign bus.ovf_err     = ovf_q;
    assign bus.unf_err     = unf_q;
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised successor of the program counter. Holds the architectural PC in a register and selects the next PC from sequential increment, branch, call or return.
- Adds an internal return-address stack (LIFO), a stall input, a programmable reset vector and sticky overflow/underflow error flags.
- Sits between the decode/control unit, which supplies the control strobes and targets, and the instruction memory address port.

Parameters:
- ADDR_W, 11, width of PC, targets and stack entries.
- STACK_DEPTH, 4, number of return-address entries (>=1).
- RESET_VEC, 0, PC value loaded on reset (ADDR_W bits).
- CNT_W, $clog2(STACK_DEPTH+1), width of the stack occupancy count (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  when high, holds all state.
- inc  input  1  advance PC by 1.
- branch_en  input  1  load branch_addr into PC.
- branch_addr  input  ADDR_W  branch target.
- call_en  input  1  push return address, jump to call_addr.
- call_addr  input  ADDR_W  call target.
- ret_en  input  1  pop stack into PC.
- pc  output  ADDR_W  current PC (registered).
- ret_top  output  ADDR_W  current top-of-stack entry; 0 when the stack is empty.
- stack_count  output  CNT_W  number of valid stack entries.
- stack_full  output  1  stack_count == STACK_DEPTH (combinational from count).
- stack_empty  output  1  stack_count == 0.
- ovf_err  output  1  sticky: a call was attempted while full.
- unf_err  output  1  sticky: a return was attempted while empty.

Behaviour:
- Reset (rst=1 at a clock edge): pc=RESET_VEC, stack_count=0, ovf_err=0, unf_err=0, ret_top=0. Stack storage contents are don't-care.
- rst has priority over everything, including stall. Reset asserted mid-call or mid-return discards the operation.
- All outputs are registered or derived from registers. A decision takes effect 1 cycle after the controlling edge; there is no combinational path from inputs to pc.
- stall=1: pc, stack and error flags all hold. All other strobes are ignored that cycle.
- When not stalled, priority is ret_en > call_en > branch_en > inc > hold.
- ret_en, stack non-empty: pc <= top entry; stack_count decrements.
- ret_en, stack empty: pc holds; unf_err <= 1; stack unchanged.
- call_en, not full: push (pc+1) mod 2^ADDR_W; pc <= call_addr; stack_count increments.
- call_en, full: call is NOT taken; pc holds; ovf_err <= 1; stack unchanged.
- branch_en: pc <= branch_addr; stack unchanged.
- inc: pc <= (pc+1) mod 2^ADDR_W. The all-ones address wraps to 0 with no flag.
- No strobe: pc holds.
- Simultaneous ret_en and call_en: only the return executes. The lower-priority strobes are dropped; no flag is raised for them.
- ovf_err and unf_err stay set until rst.
- Stack occupancy is never more than STACK_DEPTH and never less than 0.

Test Plan:
- Reset/vector, RESET_VEC=100: assert rst 1 cycle, then inc for 3 cycles -> pc=100,101,102,103; stack_empty=1; both error flags 0.
- Branch vs inc: pc=5; inc=1, branch_en=1, branch_addr=20 for 1 cycle -> pc=20. Then inc alone -> pc=21. Then no strobes 2 cycles -> pc stays 21.
- Nested call/return: pc=10, call to 50 -> pc=50, count=1, ret_top=11. Call to 80 -> pc=80, count=2, ret_top=51. Ret -> pc=51, count=1. Ret -> pc=11, count=0.
- Overflow, DEPTH=4: from pc=0, perform 4 calls -> count=4, stack_full=1. A 5th call to 200 -> pc unchanged, ovf_err=1, count=4. Then 4 rets restore the 4 return addresses in LIFO order.
- Underflow/stall/wrap: ret on empty stack -> pc holds, unf_err=1. Set pc=2047 (ADDR_W=11) with stall=1 and inc=1 -> pc stays 2047. Release stall -> pc=0.
- Reset mid-operation: count=2 with call_en=1 and rst=1 together -> pc=RESET_VEC, count=0, flags cleared. ret_en next cycle -> unf_err=1.
